// File: rtl/btb_sram_ctrl.sv
// btb_sram_ctrl: lookup/update arbiter for the 16x56 single-port BTB macro.
// Optional feature macro: BTB_WR_FWD_EN (forward pending write to lookups).
module btb_sram_ctrl #(
  parameter int STARVE_MAX = 4,
  parameter int IDX_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              lkp_valid,
  input  logic [31:0]       lkp_pc,
  output logic              lkp_ready,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [31:0]       rsp_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  output logic              upd_ready,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [IDX_W-1:0]  sram_addr0,
  output logic [59-IDX_W:0] sram_din0,
  input  logic [59-IDX_W:0] sram_dout0
);

  localparam int NENT  = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  localparam int DW    = TAG_W + 30;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_RD,
    GNT_WR
  } gnt_e;

  gnt_e             gnt;
  logic [NENT-1:0]  valid_q;
  logic             wb_vld;
  logic [IDX_W-1:0] wb_idx;
  logic [TAG_W-1:0] wb_tag;
  logic [29:0]      wb_tgt;
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_vld_q;
  logic             vld_q;
  logic [TAG_W-1:0] tag_q;
  logic             force_wr;
  logic             go;
  logic             drain;
  logic             lkp_fire;
  logic             upd_fire;
  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             src_hit;
  logic [29:0]      src_tgt;
  logic             unused_bits;

  assign lkp_idx  = lkp_pc[IDX_W+1:2];
  assign lkp_tag  = lkp_pc[31:IDX_W+2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[31:IDX_W+2];
  assign force_wr = wb_vld & (cnt_q == CNT_W'(STARVE_MAX));
  assign go       = !flush & !force_wr;

  // Port owner this cycle: flush, starved write, lookup, write, idle
  always_comb begin
    gnt = GNT_IDLE;
    unique case (1'b1)
      flush:                     gnt = GNT_IDLE;
      !flush & force_wr:         gnt = GNT_WR;
      go & lkp_valid:            gnt = GNT_RD;
      go & !lkp_valid & wb_vld:  gnt = GNT_WR;
      default:                   gnt = GNT_IDLE;
    endcase
  end

  assign drain     = gnt == GNT_WR;
  assign lkp_fire  = gnt == GNT_RD;
  assign lkp_ready = go;
  assign upd_ready = !wb_vld | drain | flush;
  assign upd_fire  = upd_valid & upd_ready;

  // Macro pins follow the grant combinationally
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    unique case (gnt)
      GNT_RD: begin
        sram_csb0  = 1'b0;
        sram_addr0 = lkp_idx;
      end
      GNT_WR: begin
        sram_csb0  = 1'b0;
        sram_web0  = 1'b0;
        sram_addr0 = wb_idx;
        sram_din0  = {wb_tag, wb_tgt};
      end
      default: ;
    endcase
  end

  // Valid bits live in flops since the macro has no reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (drain) begin
      valid_q[wb_idx] <= 1'b1;
    end
  end

  // Single-entry write buffer; a drain and a new load may share an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld <= 1'b0;
      wb_idx <= '0;
      wb_tag <= '0;
      wb_tgt <= '0;
    end else begin
      if (flush | drain) wb_vld <= 1'b0;
      if (upd_fire) begin
        wb_vld <= 1'b1;
        wb_idx <= upd_idx;
        wb_tag <= upd_tag;
        wb_tgt <= upd_target[31:2];
      end
    end
  end

  // Count arbitration losses of the buffered write, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (flush | drain) begin
      cnt_q <= '0;
    end else if (wb_vld & lkp_fire &
                 (cnt_q != CNT_W'(STARVE_MAX))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Remember issue-time valid bit and tag for the response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      vld_q     <= 1'b0;
      tag_q     <= '0;
    end else begin
      rsp_vld_q <= lkp_fire;
      if (lkp_fire) begin
        vld_q <= valid_q[lkp_idx];
        tag_q <= lkp_tag;
      end
    end
  end

`ifdef BTB_WR_FWD_EN
  logic        fwd_q;
  logic        fwd_hit_q;
  logic [29:0] fwd_tgt_q;

  // Snapshot the pending write when it shadows the looked-up entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q     <= 1'b0;
      fwd_hit_q <= 1'b0;
      fwd_tgt_q <= '0;
    end else if (lkp_fire) begin
      fwd_q     <= wb_vld & (wb_idx == lkp_idx);
      fwd_hit_q <= wb_tag == lkp_tag;
      fwd_tgt_q <= wb_tgt;
    end
  end

  assign src_hit = fwd_q ? fwd_hit_q
                 : vld_q & (tag_q == sram_dout0[DW-1:30]);
  assign src_tgt = fwd_q ? fwd_tgt_q : sram_dout0[29:0];
`else
  assign src_hit = vld_q & (tag_q == sram_dout0[DW-1:30]);
  assign src_tgt = sram_dout0[29:0];
`endif

  assign rsp_valid  = rsp_vld_q;
  assign rsp_hit    = rsp_vld_q & !flush & src_hit;
  assign rsp_target = rsp_hit ? {src_tgt, 2'b00} : '0;

  assign unused_bits = ^{lkp_pc[1:0], upd_pc[1:0], upd_target[1:0]};

endmodule
